// File: rtl/sipo_ctrl.sv
// Frame controller for an external SIPO shifter.
// It detects a start bit, enables WIDE shift edges, checks the stop bit and hands the word to a valid/ready consumer.
module sipo_ctrl #(
  parameter int WIDE = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            din,
  output logic            shift_en,
  input  logic [WIDE-1:0] sipo_q,
  output logic [WIDE-1:0] data_out,
  output logic            valid,
  input  logic            ready,
  output logic            frame_err,
  output logic            overrun,
  output logic [7:0]      frame_cnt
);

  localparam int CW = (WIDE > 1) ? $clog2(WIDE) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic            shift_en_reg;
  logic [WIDE-1:0] data_out_reg;
  logic            valid_reg;
  logic            frame_err_reg;
  logic            overrun_reg;
  logic [7:0]      frame_cnt_reg;
  logic            capture;

  // A good stop bit while still enabled is the only path that produces a word.
  assign capture = (state_reg == LOAD) && en && !din;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      shift_en_reg  <= 1'b0;
      data_out_reg  <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      frame_cnt_reg <= 8'd0;
    end else begin
      frame_err_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (en && din) begin
            state_reg    <= SHIFT;
            cnt_reg      <= '0;
            shift_en_reg <= 1'b1;
          end
        end
        SHIFT: begin
          if (!en) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            shift_en_reg <= 1'b0;
          end else if (cnt_reg == LAST) begin
            state_reg    <= LOAD;
            cnt_reg      <= '0;
            shift_en_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        LOAD: begin
          state_reg <= IDLE;
          if (en && din) frame_err_reg <= 1'b1;
        end
        default: begin
          state_reg    <= IDLE;
          cnt_reg      <= '0;
          shift_en_reg <= 1'b0;
        end
      endcase

      // An accept on the capture edge frees the slot, so the new word may load.
      if (capture) begin
        if (valid_reg && !ready) begin
          overrun_reg <= 1'b1;
        end else begin
          data_out_reg  <= sipo_q;
          valid_reg     <= 1'b1;
          frame_cnt_reg <= frame_cnt_reg + 8'd1;
        end
      end else if (valid_reg && ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign shift_en  = shift_en_reg;
  assign data_out  = data_out_reg;
  assign valid     = valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: doc/sipo_ctrl.md
SIPO_CTRL -- requirements
Module: sipo_ctrl

Interface
REQ-001 Parameter WIDE, default 4, SHALL set the SIPO word width, the data_out width and the number of shift cycles per frame (legal range 2..16).
REQ-002 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 Port en  input  1  SHALL enable frame reception.
REQ-005 Port din  input  1  SHALL carry the serial line; it is shared with the SIPO serial input.
REQ-006 Port shift_en  output  1  SHALL be the shift enable driven to the SIPO datapath.
REQ-007 Port sipo_q  input  WIDE  SHALL carry the parallel word returned by the SIPO.
REQ-008 Port data_out  output  WIDE  SHALL carry the captured frame word.
REQ-009 Port valid  output  1  SHALL indicate that data_out holds an unconsumed word.
REQ-010 Port ready  input  1  SHALL be the consumer acceptance signal.
REQ-011 Port frame_err  output  1  SHALL pulse for one cycle on a stop-bit error.
REQ-012 Port overrun  output  1  SHALL be a sticky flag set when a completed word is dropped.
REQ-013 Port frame_cnt  output  8  SHALL count frames delivered into data_out.

Function
REQ-014 The state machine SHALL have three states: IDLE, SHIFT and LOAD.
REQ-015 The bit counter SHALL be ceil(log2(WIDE)) bits wide.
REQ-016 IDLE: with en=1 and din=1 at an edge, the FSM SHALL move to SHIFT with the bit counter set to 0; otherwise it SHALL remain in IDLE.
REQ-017 shift_en SHALL be 1 exactly while the state is SHIFT (Moore output), giving exactly WIDE shift edges per frame.
REQ-018 SHIFT: the counter SHALL increment on each edge; at an edge where the counter equals WIDE-1, the FSM SHALL move to LOAD.
REQ-019 LOAD: the controller SHALL sample din as the stop bit and return to IDLE on the next edge.
REQ-020 LOAD stop bit din=0: data_out SHALL load sipo_q, valid SHALL become 1 and frame_cnt SHALL increment (mod 256), subject to REQ-023.
REQ-021 LOAD stop bit din=1: frame_err SHALL be 1 for the following cycle only, and data_out, valid and frame_cnt SHALL be unchanged.
REQ-022 Latency: valid SHALL rise at edge WIDE+1 after the start-detect edge.
REQ-023 Capture with valid=1 and ready=0: the new word SHALL be dropped, overrun SHALL be set to 1 (sticky until reset), and data_out and frame_cnt SHALL be unchanged.
REQ-024 Capture with valid=1 and ready=1 in the same cycle: the new word SHALL load, valid SHALL stay 1, and overrun SHALL stay unchanged.
REQ-025 With no capture, valid=1 and ready=1 SHALL clear valid at that edge; ready while valid=0 SHALL be ignored.
REQ-026 en=0 in SHIFT or LOAD SHALL abort to IDLE at the next edge with no capture, no frame_err and no counter change.
REQ-027 Back-to-back frames: din=1 on the cycle immediately after LOAD SHALL be detected as a new start bit.

Reset
REQ-028 reset=0 SHALL immediately force IDLE, counter=0, shift_en=0, data_out=0, valid=0, frame_err=0, overrun=0 and frame_cnt=0, including mid-frame.
REQ-029 After reset deasserts, no start SHALL be detected before the first rising edge.

Verification
Bench datapath model: WIDE=4 register with bit 0 loaded from din and a left shift on each edge with shift_en=1.
REQ-030 Nominal frame: start, bits 1,0,1,1, stop 0 -> data_out=4'b1011, valid=1 at edge 5, frame_cnt=1, shift_en high for exactly 4 cycles.
REQ-031 Stop-bit error: same frame with stop=1 -> frame_err high for 1 cycle, valid=0, frame_cnt=0.
REQ-032 Overrun: two frames 4'b1011 then 4'b0110 with ready=0 -> data_out=4'b1011, overrun=1, frame_cnt=1; then ready=1 -> valid=0 next edge.
REQ-033 Simultaneous accept and capture: ready=1 on the capture edge of frame 2 -> data_out=4'b0110, valid=1, overrun=0, frame_cnt=2.
REQ-034 Mid-frame abort: reset=0 (and separately en=0) after 2 shifts -> IDLE with all outputs at reset/held values; the next full frame captures correctly.
REQ-035 Back-to-back: frames 4'b1001 and 4'b0011 with no idle gap and ready=1 -> both delivered in order and frame_cnt=2.
